// File: rtl/gray_rx.sv
// -----------------------------------------------------------------------------
// gray_rx
//   Receiver / sequence checker for a 3-bit reflected-binary Gray counter.
//   Each sample accepted under Valid is decoded to binary and checked against
//   the previous accepted value. Steps of 0 (upstream hold) or +1 (mod 8) are
//   legal. Anything else latches an error until Resync or Reset. Accepted 7->0
//   steps are counted as wraps.
//
// Ports
//   Clk        in   1  system clock, rising edge
//   Reset      in   1  synchronous active-high reset, highest priority
//   Valid      in   1  GrayIn sample strobe
//   GrayIn     in   3  Gray code from the upstream counter
//   Resync     in   1  drop lock and clear error state, below Reset
//   Binary     out  3  registered binary decode of the last accepted code
//   Locked     out  1  high while tracking
//   Wrap       out  1  one-cycle pulse on an accepted 7->0 step
//   WrapCount  out  4  accepted wraps since Reset, saturating at 15
//   Overflow   out  1  sticky, set on the first accepted wrap
//   Error      out  1  sticky sequence-violation flag
//   BadCode    out  3  GrayIn value that caused the violation
// -----------------------------------------------------------------------------
module gray_rx (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Valid,
  input  logic [2:0] GrayIn,
  input  logic       Resync,
  output logic [2:0] Binary,
  output logic       Locked,
  output logic       Wrap,
  output logic [3:0] WrapCount,
  output logic       Overflow,
  output logic       Error,
  output logic [2:0] BadCode
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no reference code yet
    TRACK = 2'd1,  // locked, checking each sample against the last one
    ERR   = 2'd2   // violation seen, frozen until Resync/Reset
  } state_t;

  state_t     state_q,      state_d;
  logic [2:0] binary_q,     binary_d;
  logic       locked_q,     locked_d;
  logic       wrap_q,       wrap_d;
  logic [3:0] wrap_count_q, wrap_count_d;
  logic       overflow_q,   overflow_d;
  logic       error_q,      error_d;
  logic [2:0] bad_code_q,   bad_code_d;

  logic [2:0] decoded;
  logic [2:0] binary_inc;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    decoded[2] = GrayIn[2];
    decoded[1] = GrayIn[2] ^ GrayIn[1];
    decoded[0] = GrayIn[2] ^ GrayIn[1] ^ GrayIn[0];
  end

  // Natural 3-bit overflow gives the mod-8 successor.
  assign binary_inc = binary_q + 3'd1;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    binary_d     = binary_q;
    locked_d     = locked_q;
    wrap_d       = 1'b0;  // pulse: only asserted on the accepting cycle
    wrap_count_d = wrap_count_q;
    overflow_d   = overflow_q;
    error_d      = error_q;
    bad_code_d   = bad_code_q;

    if (Resync) begin
      // Any same-cycle sample is discarded; Binary and wrap history survive.
      state_d    = IDLE;
      locked_d   = 1'b0;
      error_d    = 1'b0;
      bad_code_d = 3'b000;
    end else if (Valid) begin
      unique case (state_q)
        IDLE: begin
          // First sample becomes the reference; nothing to check it against.
          state_d  = TRACK;
          binary_d = decoded;
          locked_d = 1'b1;
        end
        TRACK: begin
          if (decoded == binary_q) begin
            // Upstream held its count; nothing changes.
          end else if (decoded == binary_inc) begin
            binary_d = decoded;
            if (binary_q == 3'd7) begin
              wrap_d     = 1'b1;
              overflow_d = 1'b1;
              if (wrap_count_q != 4'hF) begin
                wrap_count_d = wrap_count_q + 4'd1;
              end
            end
          end else begin
            // Skip or backward step: keep the last good value for debug.
            state_d    = ERR;
            locked_d   = 1'b0;
            error_d    = 1'b1;
            bad_code_d = GrayIn;
          end
        end
        ERR: begin
          // Samples ignored until Resync or Reset.
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    if (Reset) begin
      state_q      <= IDLE;
      binary_q     <= 3'b000;
      locked_q     <= 1'b0;
      wrap_q       <= 1'b0;
      wrap_count_q <= 4'd0;
      overflow_q   <= 1'b0;
      error_q      <= 1'b0;
      bad_code_q   <= 3'b000;
    end else begin
      state_q      <= state_d;
      binary_q     <= binary_d;
      locked_q     <= locked_d;
      wrap_q       <= wrap_d;
      wrap_count_q <= wrap_count_d;
      overflow_q   <= overflow_d;
      error_q      <= error_d;
      bad_code_q   <= bad_code_d;
    end
  end

  assign Binary    = binary_q;
  assign Locked    = locked_q;
  assign Wrap      = wrap_q;
  assign WrapCount = wrap_count_q;
  assign Overflow  = overflow_q;
  assign Error     = error_q;
  assign BadCode   = bad_code_q;

endmodule

// File: doc/gray_rx.md
GRAY_RX -- requirements
Module: gray_rx

Interface
REQ-001 Clock and reset: one clock, Clk, rising-edge active; reset, Reset, is synchronous and active-high.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous active-high reset; highest priority.
REQ-004 Valid  input  1  GrayIn sample strobe; sampled on rising edge.
REQ-005 GrayIn  input  3  reflected-binary Gray code from the upstream 3-bit Gray counter.
REQ-006 Resync  input  1  drops lock and clears error state; second priority after Reset.
REQ-007 Binary  output  3  registered binary decode of the last accepted code.
REQ-008 Locked  output  1  high while in TRACK.
REQ-009 Wrap  output  1  single-cycle pulse on an accepted 7->0 step.
REQ-010 WrapCount  output  4  accepted wraps since Reset; saturates at 15.
REQ-011 Overflow  output  1  sticky; set on the first accepted wrap.
REQ-012 Error  output  1  sticky sequence-violation flag; high in ERR.
REQ-013 BadCode  output  3  GrayIn value that caused the violation.

Function
REQ-014 Decode: b[2]=g[2]; b[1]=g[2]^g[1]; b[0]=g[2]^g[1]^g[0].
- Legal order: 000,001,011,010,110,111,101,100, then 000 again.
REQ-015 All outputs are registered; the response to a sample appears the cycle after the edge where Valid=1.
REQ-016 States: IDLE (no reference code), TRACK (locked), ERR (violation seen).
REQ-017 IDLE with Valid=1 -> TRACK; Binary=decode(GrayIn); no sequence check; Wrap stays 0.
REQ-018 TRACK with Valid=1, d=decode(GrayIn), p=Binary:
- d==p: hold; outputs unchanged, no error (models upstream En=0).
- d==(p+1) mod 8: Binary=d.
- Additionally, if p==7 and d==0: Wrap=1 for one cycle, WrapCount+1 (saturating at 15), Overflow=1.
- Any other d: go to ERR; Error=1; BadCode=GrayIn; Binary holds p.
REQ-019 ERR: Valid is ignored; Binary, BadCode and Error hold until Resync or Reset.
REQ-020 Valid=0 in any state: no state or output change; Wrap=0.
REQ-021 Resync=1 (any state): next state IDLE; Locked=0, Error=0, BadCode=000, Wrap=0.
- Binary, WrapCount and Overflow are preserved.
- A Valid sample in the same cycle is discarded.
REQ-022 Wrap is never high for two consecutive cycles; at WrapCount=15 a wrap still pulses Wrap but the count holds at 15.

Reset
REQ-023 Reset=1 at a rising edge forces, next cycle: state IDLE, Binary=000, Locked=0, Wrap=0, WrapCount=0, Overflow=0, Error=0, BadCode=000.
REQ-024 Reset overrides Resync and Valid in the same cycle, and aborts any state mid-operation.
- Sampled data in that cycle is discarded.

Verification
REQ-025 Full cycle: Reset, then Valid=1 with GrayIn 000,001,011,010,110,111,101,100,000 on consecutive cycles.
- Binary steps 0..7 then 0; Locked=1 from the first sample.
- Wrap=1 exactly one cycle, after the final 000; WrapCount=1; Overflow=1; Error=0.
REQ-026 Hold and gaps: GrayIn 001,011,011,011 with Valid=0 gaps interleaved.
- Binary=2 throughout the repeats; Error=0; Wrap=0.
REQ-027 Skip: GrayIn 000,001,010.
- Error=1, BadCode=010, Locked=0, Binary=1.
- Further Valid samples (e.g. 110) change nothing.
REQ-028 Backward step: GrayIn 011 then 001 -> Error=1, BadCode=001, Binary=2.
REQ-029 Recovery: from ERR with WrapCount=1, assert Resync together with Valid on GrayIn=111, then the next cycle Valid with GrayIn=110.
- Resync cycle: Error=0, Locked=0, sample discarded.
- Next cycle: Locked=1, Binary=4, WrapCount=1, Overflow=1.
REQ-030 Reset mid-operation: in TRACK with Binary=5 and WrapCount=3, assert Reset together with Valid=1 on GrayIn=100.
- Next cycle all outputs equal the REQ-023 values.
- Drive 17 full Gray cycles: WrapCount saturates at 15, with one Wrap pulse per cycle.
